// File: rtl/countdown_controller_if.sv
// ============================================================================
// countdown_controller_if : control/display bundle for the countdown controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface countdown_controller_if;
  logic       start;
  logic       cancel;
  logic       pause;
  logic [7:0] init_bcd;
  logic [8:0] seconds;
  logic       busy;
  logic       timeout;

  modport master (
    output start, cancel, pause, init_bcd,
    input  seconds, busy, timeout
  );

  modport slave (
    input  start, cancel, pause, init_bcd,
    output seconds, busy, timeout
  );
endinterface

`default_nettype wire

// File: rtl/countdown_controller.sv
// ============================================================================
// countdown_controller : BCD seconds countdown (0-99) with 1 Hz prescaler
// Rev 1.0
// ============================================================================
`default_nettype none

module countdown_controller #(
  parameter int CYCLES_PER_SEC = 100_000_000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  countdown_controller_if.slave bus
);

  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(CYCLES_PER_SEC - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [8:0]    r_seconds, w_seconds_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_timeout, w_timeout_nxt;

  logic [7:0]    w_load_val;
  logic [7:0]    w_dec_val;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign w_load_val = {clamp_digit(bus.init_bcd[7:4]), clamp_digit(bus.init_bcd[3:0])};

  // Borrow from tens when ones is 0; a running count is never 00 so tens never wraps.
  assign w_dec_val = (r_seconds[3:0] != 4'd0)
                   ? {r_seconds[7:4], r_seconds[3:0] - 4'd1}
                   : {r_seconds[7:4] - 4'd1, 4'd9};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_seconds <= 9'h000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_seconds <= w_seconds_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_seconds_nxt = r_seconds;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;

    if (bus.cancel) begin
      w_state_nxt   = IDLE;
      w_seconds_nxt = 9'h000;
      w_busy_nxt    = 1'b0;
    end else if (bus.start) begin
      if (w_load_val == 8'h00) begin
        w_state_nxt   = IDLE;
        w_seconds_nxt = 9'h000;
        w_busy_nxt    = 1'b0;
        w_timeout_nxt = 1'b1;
      end else begin
        w_state_nxt   = RUN;
        w_seconds_nxt = {1'b1, w_load_val};
        w_presc_nxt   = '0;
        w_busy_nxt    = 1'b1;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (!bus.pause) begin
            if (r_presc == C_PRESC_LAST) begin
              w_presc_nxt = '0;
              if (w_dec_val == 8'h00) begin
                w_state_nxt   = IDLE;
                w_seconds_nxt = 9'h000;
                w_busy_nxt    = 1'b0;
                w_timeout_nxt = 1'b1;
              end else begin
                w_seconds_nxt = {1'b1, w_dec_val};
              end
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.seconds = r_seconds;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_countdown_controller.sv
// ============================================================================
// tb_countdown_controller : directed + random checks against a seconds-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_countdown_controller;

  localparam int CPS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  countdown_controller_if bus();

  countdown_controller #(.CYCLES_PER_SEC(CPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: running flag, remaining seconds as a plain integer, cycles into the current second.
  bit m_run;
  int m_rem;
  int m_phase;
  bit m_to;

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic logic [8:0] exp_seconds();
    logic [8:0] v;
    v = 9'h000;
    if (m_run) v = {1'b1, 4'(m_rem / 10), 4'(m_rem % 10)};
    return v;
  endfunction

  task automatic model_step();
    int v;
    m_to = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_rem = 0; m_phase = 0;
    end else if (bus.cancel) begin
      m_run = 1'b0; m_rem = 0;
    end else if (bus.start) begin
      v = clamp9(int'(bus.init_bcd[7:4])) * 10 + clamp9(int'(bus.init_bcd[3:0]));
      if (v == 0) begin
        m_run = 1'b0; m_rem = 0; m_to = 1'b1;
      end else begin
        m_run = 1'b1; m_rem = v; m_phase = 0;
      end
    end else if (m_run && !bus.pause) begin
      m_phase++;
      if (m_phase == CPS) begin
        m_phase = 0;
        m_rem--;
        if (m_rem == 0) begin
          m_run = 1'b0; m_to = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit c, input bit p, input logic [7:0] v);
    reset        = r;
    bus.start    = s;
    bus.cancel   = c;
    bus.pause    = p;
    bus.init_bcd = v;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("seconds", bus.seconds, exp_seconds());
    check("busy", {8'h00, bus.busy}, {8'h00, m_run});
    check("timeout", {8'h00, bus.timeout}, {8'h00, m_to});
  endtask

  task automatic idle_steps(input int n);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_run = 1'b0; m_rem = 0; m_phase = 0; m_to = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    step();
    check("reset_seconds", bus.seconds, 9'h000);
    idle_steps(10);

    // Plain 3-second run
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    step();
    check("start03", bus.seconds, 9'h103);
    idle_steps(4);
    check("dec_to_02", bus.seconds, 9'h102);
    idle_steps(8);
    check("expiry_timeout", {8'h00, bus.timeout}, 9'h001);
    check("expiry_seconds", bus.seconds, 9'h000);
    idle_steps(1);
    check("timeout_drop", {8'h00, bus.timeout}, 9'h000);

    // BCD borrow
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    step();
    check("start10", bus.seconds, 9'h110);
    idle_steps(4);
    check("borrow_09", bus.seconds, 9'h109);
    idle_steps(4);
    check("borrow_08", bus.seconds, 9'h108);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step();

    // Pause for three edges starting at E0+2
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    step();
    idle_steps(1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step();
    idle_steps(2);
    check("pause_hold", bus.seconds, 9'h102);
    idle_steps(1);
    check("pause_dec", bus.seconds, 9'h101);
    idle_steps(4);
    check("pause_timeout", {8'h00, bus.timeout}, 9'h001);

    // Corner loads
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    check("zero_timeout", {8'h00, bus.timeout}, 9'h001);
    check("zero_busy", {8'h00, bus.busy}, 9'h000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    step();
    check("clamp_ff", bus.seconds, 9'h199);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    step();
    check("clamp_a5", bus.seconds, 9'h195);

    // Cancel together with start at E0+5
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h05);
    step();
    idle_steps(4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h07);
    step();
    check("cancel_seconds", bus.seconds, 9'h000);
    check("cancel_no_to", {8'h00, bus.timeout}, 9'h000);

    // Restart at E0+6
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h09);
    step();
    idle_steps(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    step();
    check("restart02", bus.seconds, 9'h102);
    idle_steps(3);
    check("restart_hold", bus.seconds, 9'h102);
    idle_steps(1);
    check("restart_dec", bus.seconds, 9'h101);

    // Reset mid-run
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
    step();
    idle_steps(6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("midrun_reset", bus.seconds, 9'h000);
    check("midrun_reset_to", {8'h00, bus.timeout}, 9'h000);
    idle_steps(2);

    // Random traffic, biased toward short counts so expiry is common
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 1) == 0) ? {4'($urandom_range(0, 1)), 4'($urandom_range(0, 3))}
                                      : 8'($urandom);
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 5) == 0),
            v);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
